pulse_counter_bcd: RTL and testbench

- Parametrised successor to the team's two-digit pulse/millisecond counter.
- Qualifies input pulses by minimum high width. Each pulse is counted once.
- Counts qualified pulses up or down, modulo MODULUS, directly in BCD across N_DIGITS decades. No separate binary-to-BCD converter.
- Sits between a synchronous pulse source and the display/decoder logic. Wrap and strobe outputs are available for cascading.

---
 rtl/pulse_counter_pkg.sv | 40 ++++
 rtl/pulse_counter_bcd_digit.sv | 63 ++++++
 rtl/pulse_counter_bcd.sv | 175 +++++++++++++++++
 tb/tb_pulse_counter_bcd.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_counter_pkg
// Description : Shared types, constants and helpers for the BCD pulse counter.
//               - qual_state_t : pulse-width qualifier states
//               - to_bcd()     : integer -> packed BCD (up to MAX_DIGITS decades)
// Revision    : 1.0  initial release
// ============================================================================
package pulse_counter_pkg;

  localparam int MAX_DIGITS = 6;
  localparam int MAX_BCD_W  = 4 * MAX_DIGITS;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    COUNTED = 2'd2
  } qual_state_t;

  // Converts a non-negative integer into packed BCD; decades above 'digits'
  // are left at zero. Used at elaboration time to build reload constants.
  function automatic logic [MAX_BCD_W-1:0] to_bcd(input int value, input int digits);
    logic [MAX_BCD_W-1:0] result;
    int                   v;
    result = '0;
    v      = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        result[i*4 +: 4] = 4'(v % 10);
      end
      v = v / 10;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_counter_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One BCD decade of an up/down counter chain.
//   clk       in   clock
//   rst       in   synchronous active-high reset (digit -> 0)
//   clear     in   synchronous clear (digit -> 0), above load/en
//   load      in   parallel load of load_val, above en
//   load_val  in   4-bit BCD value to load
//   en        in   step this decade by one
//   up        in   1 = increment, 0 = decrement
//   digit     out  registered BCD digit
//   carry_out out  carry (up, digit==9) or borrow (down, digit==0) while en
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
  import pulse_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = BCD_ZERO;
    end else if (load) begin
      digit_d = load_val;
    end else if (en) begin
      if (up) begin
        digit_d = (digit_q == BCD_NINE) ? BCD_ZERO : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_ZERO) ? BCD_NINE : digit_q - 4'd1;
      end
    end
  end

  // The next decade steps exactly when this one rolls over in the
  // current direction, so en ripples combinationally along the chain.
  assign carry_out = en && (up ? (digit_q == BCD_NINE) : (digit_q == BCD_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule
`default_nettype wire

// File: rtl/pulse_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module      : pulse_counter_bcd
// Description : Width-qualified pulse counter, up/down modulo MODULUS, kept
//               directly in BCD over N_DIGITS decades.
//   CLK       in   clock, rising edge
//   Reset     in   synchronous active-high reset, highest priority
//   Pulse     in   synchronous pulse input
//   Dir       in   1 = up, 0 = down (sampled at the qualify edge)
//   Clear     in   synchronous count clear (qualifier unaffected)
//   Hold      in   freeze count (qualifier unaffected)
//   Digits    out  BCD count, [3:0] = units
//   Qualified out  one-cycle strobe per accepted pulse
//   Wrap      out  one-cycle strobe when the count wraps
// Revision    : 1.0  initial release
// ============================================================================
module pulse_counter_bcd
  import pulse_counter_pkg::*;
#(
  parameter int N_DIGITS  = 2,
  parameter int MIN_WIDTH = 4,
  parameter int MODULUS   = 20
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Pulse,
  input  logic                  Dir,
  input  logic                  Clear,
  input  logic                  Hold,
  output logic [4*N_DIGITS-1:0] Digits,
  output logic                  Qualified,
  output logic                  Wrap
);

  localparam int BCD_W  = 4 * N_DIGITS;
  localparam int WCNT_W = $clog2(MIN_WIDTH + 1);

  localparam logic [BCD_W-1:0]  MAX_BCD     = BCD_W'(to_bcd(MODULUS - 1, N_DIGITS));
  localparam logic [WCNT_W-1:0] MIN_WIDTH_W = WCNT_W'(MIN_WIDTH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_n_digits
    $error("pulse_counter_bcd: N_DIGITS must be 1..6");
  end
  if (MIN_WIDTH < 1 || MIN_WIDTH > 255) begin : g_bad_min_width
    $error("pulse_counter_bcd: MIN_WIDTH must be 1..255");
  end
  if (MODULUS < 2 || MODULUS > 10**N_DIGITS) begin : g_bad_modulus
    $error("pulse_counter_bcd: MODULUS must be 2..10**N_DIGITS");
  end

  // --------------------------------------------------------------------------
  // Pulse-width qualifier
  // --------------------------------------------------------------------------
  qual_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              qualify;

  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    qualify = 1'b0;
    case (state_q)
      IDLE: begin
        if (Pulse) begin
          wcnt_d = WCNT_W'(1);
          if (MIN_WIDTH == 1) begin
            state_d = COUNTED;
            qualify = 1'b1;
          end else begin
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (Pulse) begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == MIN_WIDTH_W) begin
            state_d = COUNTED;
            qualify = 1'b1;
          end
        end else begin
          // Too short: drop it silently and re-arm.
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      COUNTED: begin
        // A long pulse is counted once; wait for it to go low.
        if (!Pulse) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Count control: modulus compare and wrap reload
  // --------------------------------------------------------------------------
  logic [BCD_W-1:0]  digits;
  logic              step;
  logic              at_top;
  logic              at_zero;
  logic              wrap_d;
  logic              wrap_q;
  logic              qualified_d;
  logic              qualified_q;
  logic [BCD_W-1:0]  load_val;
  logic [N_DIGITS:0] en_chain;
  logic              carry_top_unused;

  assign step    = qualify && !Clear && !Hold;
  assign at_top  = (digits == MAX_BCD);
  assign at_zero = (digits == '0);

  // A wrap replaces the carry chain with a parallel load, so a modulus
  // below 10**N_DIGITS never lets a decade pass the terminal value.
  assign wrap_d      = step && (Dir ? at_top : at_zero);
  assign load_val    = Dir ? '0 : MAX_BCD;
  assign en_chain[0] = step && !wrap_d;
  assign qualified_d = qualify;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (CLK),
      .rst       (Reset),
      .clear     (Clear),
      .load      (wrap_d),
      .load_val  (load_val[i*4 +: 4]),
      .en        (en_chain[i]),
      .up        (Dir),
      .digit     (digits[i*4 +: 4]),
      .carry_out (en_chain[i+1])
    );
  end

  // Top decade's carry is meaningless: the wrap compare handles rollover.
  assign carry_top_unused = en_chain[N_DIGITS];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      qualified_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      qualified_q <= qualified_d;
      wrap_q      <= wrap_d;
    end
  end

  assign Digits    = digits;
  assign Qualified = qualified_q;
  assign Wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_counter_bcd
// Description : Self-checking bench for pulse_counter_bcd. Instance A uses the
//               defaults (2 digits, width 4, modulus 20); instance B uses
//               3 digits, width 1, modulus 1000.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_counter_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst_a = 1'b1, pls_a = 1'b0, dir_a = 1'b1, clr_a = 1'b0, hold_a = 1'b0;
  logic [7:0]  dig_a;
  logic        q_a, w_a;
  // Instance B
  logic        rst_b = 1'b1, pls_b = 1'b0, dir_b = 1'b1, clr_b = 1'b0, hold_b = 1'b0;
  logic [11:0] dig_b;
  logic        q_b, w_b;

  pulse_counter_bcd dut_a (
    .CLK(clk), .Reset(rst_a), .Pulse(pls_a), .Dir(dir_a), .Clear(clr_a),
    .Hold(hold_a), .Digits(dig_a), .Qualified(q_a), .Wrap(w_a)
  );

  pulse_counter_bcd #(.N_DIGITS(3), .MIN_WIDTH(1), .MODULUS(1000)) dut_b (
    .CLK(clk), .Reset(rst_b), .Pulse(pls_b), .Dir(dir_b), .Clear(clr_b),
    .Hold(hold_b), .Digits(dig_b), .Qualified(q_b), .Wrap(w_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 50)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int int2bcd(input int value);
    int r = 0;
    int v = value;
    for (int i = 0; i < 6; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Model: a pulse qualifies when its run of consecutive high samples reaches
  // mw; the count is a plain integer modulo mod.
  task automatic model_step(input bit rst, input bit pls, input bit dir,
                            input bit clr, input bit hold,
                            input int mw, input int mod,
                            inout int run, inout int cnt,
                            output bit q, output bit w);
    q = 1'b0;
    w = 1'b0;
    if (rst) begin
      run = 0;
      cnt = 0;
    end else begin
      if (pls) begin
        run = run + 1;
        if (run == mw) q = 1'b1;
      end else begin
        run = 0;
      end
      if (clr) begin
        cnt = 0;
      end else if (q && !hold) begin
        if (dir) begin
          if (cnt == mod - 1) begin cnt = 0; w = 1'b1; end
          else cnt = cnt + 1;
        end else begin
          if (cnt == 0) begin cnt = mod - 1; w = 1'b1; end
          else cnt = cnt - 1;
        end
      end
    end
  endtask

  int run_a = 0, cnt_a = 0, run_b = 0, cnt_b = 0;
  bit eq_a, ew_a, eq_b, ew_b;
  int nq_a = 0, nw_a = 0, nq_b = 0, nw_b = 0;

  always @(posedge clk) begin
    model_step(rst_a, pls_a, dir_a, clr_a, hold_a, 4, 20,   run_a, cnt_a, eq_a, ew_a);
    model_step(rst_b, pls_b, dir_b, clr_b, hold_b, 1, 1000, run_b, cnt_b, eq_b, ew_b);
    #2;
    check("A Digits",    int'(dig_a), int2bcd(cnt_a));
    check("A Qualified", int'(q_a),   int'(eq_a));
    check("A Wrap",      int'(w_a),   int'(ew_a));
    check("B Digits",    int'(dig_b), int2bcd(cnt_b));
    check("B Qualified", int'(q_b),   int'(eq_b));
    check("B Wrap",      int'(w_b),   int'(ew_b));
    if (q_a) nq_a++;
    if (w_a) nw_a++;
    if (q_b) nq_b++;
    if (w_b) nw_b++;
  end

  task automatic pulse_a(input int hi, input int lo);
    repeat (hi) begin @(negedge clk); pls_a = 1'b1; end
    repeat (lo) begin @(negedge clk); pls_a = 1'b0; end
  endtask

  task automatic pulse_b(input int hi, input int lo);
    repeat (hi) begin @(negedge clk); pls_b = 1'b1; end
    repeat (lo) begin @(negedge clk); pls_b = 1'b0; end
  endtask

  task automatic reset_a();
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
  endtask

  int nq_snap;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset Digits",    int'(dig_a), 'h00);
    check("reset Qualified", int'(q_a),   0);
    check("reset Wrap",      int'(w_a),   0);
    rst_a = 1'b0;

    // Up count through the full modulus
    dir_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      pulse_a(4, 2);
      if (i == 1)  check("up 1",  int'(dig_a), 'h01);
      if (i == 10) check("up 10", int'(dig_a), 'h10);
      if (i == 19) check("up 19", int'(dig_a), 'h19);
      if (i == 20) check("up 20 wrap", int'(dig_a), 'h00);
    end
    check("up qual count", nq_a, 20);
    check("up wrap count", nw_a, 1);

    // Short pulses rejected, long pulse counted once
    repeat (3) pulse_a(3, 2);
    check("short Digits", int'(dig_a), 'h00);
    check("short qual count", nq_a, 20);
    pulse_a(50, 2);
    check("long qual count", nq_a, 21);
    check("long Digits", int'(dig_a), 'h01);

    // Down count from reset
    reset_a();
    dir_a = 1'b0;
    pulse_a(4, 2);
    check("down wrap Digits", int'(dig_a), 'h19);
    check("down wrap count", nw_a, 2);
    pulse_a(4, 2);
    check("down 18", int'(dig_a), 'h18);
    repeat (8) pulse_a(4, 2);
    check("down 10", int'(dig_a), 'h10);
    pulse_a(4, 2);
    check("down borrow 09", int'(dig_a), 'h09);
    repeat (2) pulse_a(4, 2);
    check("down 07", int'(dig_a), 'h07);

    // Clear coincident with the qualify edge
    repeat (3) begin @(negedge clk); pls_a = 1'b1; end
    @(negedge clk); pls_a = 1'b1; clr_a = 1'b1;
    @(negedge clk);
    check("clear Qualified", int'(q_a),   1);
    check("clear Digits",    int'(dig_a), 'h00);
    check("clear Wrap",      int'(w_a),   0);
    pls_a = 1'b0; clr_a = 1'b0;
    @(negedge clk);

    // Hold: strobe still fires, count frozen
    dir_a = 1'b1; hold_a = 1'b1;
    nq_snap = nq_a;
    pulse_a(4, 2);
    check("hold Digits", int'(dig_a), 'h00);
    check("hold qual count", nq_a, nq_snap + 1);
    hold_a = 1'b0;

    // Reset on the 3rd high sample of a pulse that stays high
    pulse_a(4, 2);
    check("pre-reset Digits", int'(dig_a), 'h01);
    @(negedge clk); pls_a = 1'b1;
    @(negedge clk);
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    check("mid-pulse reset Digits", int'(dig_a), 'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("post-reset Qualified", int'(q_a), (k == 4) ? 1 : 0);
    end
    check("post-reset Digits", int'(dig_a), 'h01);
    pls_a = 1'b0;
    @(negedge clk);

    // Instance B: 3 decades, modulus 1000, width 1
    rst_b = 1'b0;
    dir_b = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      pulse_b(1, 1);
      if (i == 99)   check("B 099", int'(dig_b), 'h099);
      if (i == 100)  check("B carry 100", int'(dig_b), 'h100);
      if (i == 999)  check("B 999", int'(dig_b), 'h999);
      if (i == 1000) check("B wrap 000", int'(dig_b), 'h000);
    end
    check("B wrap count", nw_b, 1);
    check("B qual count", nq_b, 1000);
    dir_b = 1'b0;
    pulse_b(1, 1);
    check("B down wrap", int'(dig_b), 'h999);
    check("B wrap count 2", nw_b, 2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
